// File: rtl/radix4_div_pkg.sv
// Shared types and constants for the radix-4 divider and its digit stage.
package radix4_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DIGIT_BITS    = 2;
  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/radix4_div_step.sv
// Combinational radix-4 digit stage: pick the largest multiple of D that fits, subtract it.
module radix4_div_step
  import radix4_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0]      i_rem,
  input  logic [WIDTH+1:0]      i_d1,
  input  logic [WIDTH+1:0]      i_d2,
  input  logic [WIDTH+1:0]      i_d3,
  output logic [DIGIT_BITS-1:0] o_digit,
  output logic [WIDTH-1:0]      o_rem
);

  // NOTE: every output gets a default first so no path through the if-chain infers a latch.
  always_comb begin
    o_digit = 2'd0;
    o_rem   = WIDTH'(i_rem);
    if (i_rem >= i_d3) begin
      o_digit = 2'd3;
      o_rem   = WIDTH'(i_rem - i_d3);
    end else if (i_rem >= i_d2) begin
      o_digit = 2'd2;
      o_rem   = WIDTH'(i_rem - i_d2);
    end else if (i_rem >= i_d1) begin
      o_digit = 2'd1;
      o_rem   = WIDTH'(i_rem - i_d1);
    end
  end

endmodule

// File: rtl/radix4_divider.sv
// Sequential radix-4 divider: two quotient bits per clock behind a start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands with truncation toward zero; default is unsigned.
module radix4_divider
  import radix4_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int STEPS = WIDTH / DIGIT_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t                r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_dvd;
  logic [WIDTH-1:0]      r_rem;
  logic [WIDTH-1:0]      r_d;
  logic [WIDTH+1:0]      r_d3;
  logic                  r_div0;

  logic [WIDTH-1:0]      w_dividend_mag, w_divisor_mag;
  logic [WIDTH+1:0]      w_rem_shifted, w_d1, w_d2;
  logic [WIDTH-1:0]      w_rem_next;
  logic [DIGIT_BITS-1:0] w_digit;
  logic [WIDTH-1:0]      w_rem_mag, w_quot_res, w_rem_res;
  logic                  w_accept;

  assign w_accept      = (r_state == IDLE) && start;
  assign w_rem_shifted = {r_rem, r_dvd[WIDTH-1 -: DIGIT_BITS]};
  assign w_d1          = {2'b00, r_d};
  assign w_d2          = {1'b0, r_d, 1'b0};
  // On divide-by-zero the dividend never shifts out, so r_dvd still holds it for the remainder.
  assign w_rem_mag     = r_div0 ? r_dvd : r_rem;

  radix4_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem   (w_rem_shifted),
    .i_d1    (w_d1),
    .i_d2    (w_d2),
    .i_d3    (r_d3),
    .o_digit (w_digit),
    .o_rem   (w_rem_next)
  );

`ifdef SIGNED_DIV_EN
  logic r_neg_q, r_neg_r;

  assign w_dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_quot_res     = r_div0 ? '1 : (r_neg_q ? -r_dvd : r_dvd);
  assign w_rem_res      = r_neg_r ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign w_dividend_mag = dividend;
  assign w_divisor_mag  = divisor;
  assign w_quot_res     = r_div0 ? '1 : r_dvd;
  assign w_rem_res      = w_rem_mag;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = (divisor == '0) ? FIN : CALC;
      CALC:    if (r_cnt == '0) w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_d         <= '0;
      r_d3        <= '0;
      r_div0      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd  <= w_dividend_mag;
            r_d    <= w_divisor_mag;
            r_d3   <= {2'b00, w_divisor_mag} + {1'b0, w_divisor_mag, 1'b0};
            r_rem  <= '0;
            r_cnt  <= CNT_W'(STEPS - 1);
            r_div0 <= (divisor == '0);
            busy   <= (divisor != '0);
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[WIDTH-DIGIT_BITS-1:0], w_digit};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) busy <= 1'b0;
        end
        FIN: begin
          done        <= 1'b1;
          quotient    <= w_quot_res;
          remainder   <= w_rem_res;
          div_by_zero <= r_div0;
        end
        default: ;
      endcase
    end
  end

endmodule
